// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: tracks slot sequence from a frame-sync marker and
// reassembles four serial slots into a double-buffered parallel frame.
module tdm_demux4 #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MISS_MAX = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               en,
  input  logic               sync,
  output logic [4*WIDTH-1:0] O,
  output logic [1:0]         S,
  output logic               frame_valid,
  output logic               locked,
  output logic               sync_err
);

  localparam int unsigned SHW = 3 * WIDTH;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_n;
  logic [1:0]       s_n;
  logic [2:0]       miss, miss_n, miss_inc;
  logic [SHW-1:0]   shadow, shadow_n;
  logic [4*WIDTH-1:0] o_n;
  logic             fv_n, se_n;

  // State and all output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      S           <= 2'd0;
      miss        <= 3'd0;
      shadow      <= '0;
      O           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      S           <= s_n;
      miss        <= miss_n;
      shadow      <= shadow_n;
      O           <= o_n;
      frame_valid <= fv_n;
      sync_err    <= se_n;
    end
  end

  assign locked   = (state == LOCKED);
  assign miss_inc = miss + 3'd1;

  // Slot tracking, flywheel and resync decisions
  always_comb begin
    state_n  = state;
    s_n      = S;
    miss_n   = miss;
    shadow_n = shadow;
    o_n      = O;
    fv_n     = 1'b0;
    se_n     = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (sync) begin
            shadow_n[WIDTH-1:0] = din;
            s_n                 = 2'd1;
            miss_n              = 3'd0;
            state_n             = LOCKED;
          end
        end
        LOCKED: begin
          if (S == 2'd0) begin
            if (!sync && (miss_inc >= 3'(MISS_MAX))) begin
              state_n = HUNT;
              s_n     = 2'd0;
              miss_n  = 3'd0;
            end else begin
              shadow_n[WIDTH-1:0] = din;
              s_n                 = 2'd1;
              miss_n              = sync ? 3'd0 : miss_inc;
            end
          end else if (sync) begin
            // Misplaced marker: drop the partial frame and restart at slot 0
            se_n     = 1'b1;
            shadow_n = {{(2*WIDTH){1'b0}}, din};
            s_n      = 2'd1;
            miss_n   = 3'd0;
          end else begin
            case (S)
              2'd1: begin
                shadow_n[WIDTH +: WIDTH] = din;
                s_n                      = 2'd2;
              end
              2'd2: begin
                shadow_n[2*WIDTH +: WIDTH] = din;
                s_n                        = 2'd3;
              end
              default: begin
                o_n  = {din, shadow};
                fv_n = 1'b1;
                s_n  = 2'd0;
              end
            endcase
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: stimulus pushes expected frames, a negedge
// monitor pops and compares on every frame_valid pulse.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] din;
  logic       en;
  logic       sync;
  logic [3:0] O;
  logic [1:0] S;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic       fv_prev = 1'b0;

  tdm_demux4 #(.WIDTH(1), .MISS_MAX(2)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .sync(sync),
    .O(O), .S(S), .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic beat(input logic d, input logic sy);
    en = 1'b1; din = d; sync = sy;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    en = 1'b0; sync = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (frame_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame_valid: O=%b at %0t", O, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (O !== e) begin
          errors++;
          $display("FAIL frame_O: got %b expected %b at %0t", O, e, $time);
        end
      end
      checks++;
      if (fv_prev) begin
        errors++;
        $display("FAIL fv_width: frame_valid high two cycles at %0t", $time);
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; din = 1'b0; sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_O", 32'(O), 32'h0);
    check("rst_S", 32'(S), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    rst_n = 1'b1;

    // HUNT ignores unsynced beats
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0);
    check("hunt_S", 32'(S), 32'h0);
    check("hunt_locked", 32'(locked), 32'h0);
    check("hunt_O", 32'(O), 32'h0);

    // Clean back-to-back frames
    exp_q.push_back(4'b1101);
    beat(1'b1, 1'b1);
    check("lock_locked", 32'(locked), 32'h1);
    check("lock_S", 32'(S), 32'h1);
    beat(1'b0, 1'b0);
    check("slot_S2", 32'(S), 32'h2);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    check("f1_S", 32'(S), 32'h0);
    check("f1_fv", 32'(frame_valid), 32'h1);
    check("f1_O", 32'(O), 32'hD);
    exp_q.push_back(4'b0110);
    beat(1'b0, 1'b1);
    check("f2_fv_low", 32'(frame_valid), 32'h0);
    check("f2_O_hold", 32'(O), 32'hD);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    check("f2_O", 32'(O), 32'h6);

    // Gapped strobe
    exp_q.push_back(4'b1101);
    beat(1'b1, 1'b1);
    idle(2);
    check("gap_S1", 32'(S), 32'h1);
    check("gap_fv", 32'(frame_valid), 32'h0);
    beat(1'b0, 1'b0);
    idle(2);
    check("gap_S2", 32'(S), 32'h2);
    beat(1'b1, 1'b0);
    idle(2);
    check("gap_S3", 32'(S), 32'h3);
    beat(1'b1, 1'b0);
    check("gap_O", 32'(O), 32'hD);
    check("gap_fv_hi", 32'(frame_valid), 32'h1);

    // Misaligned sync at S=2
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    check("mis_S2", 32'(S), 32'h2);
    beat(1'b1, 1'b1);
    check("mis_sync_err", 32'(sync_err), 32'h1);
    check("mis_S", 32'(S), 32'h1);
    check("mis_fv", 32'(frame_valid), 32'h0);
    exp_q.push_back(4'b1001);
    beat(1'b0, 1'b0);
    check("mis_err_clr", 32'(sync_err), 32'h0);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    check("mis_O", 32'(O), 32'h9);

    // Sync loss: first miss flywheels, second drops lock
    exp_q.push_back(4'b1010);
    beat(1'b0, 1'b0);
    check("fly_locked", 32'(locked), 32'h1);
    check("fly_S", 32'(S), 32'h1);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    check("fly_O", 32'(O), 32'hA);
    beat(1'b1, 1'b0);
    check("loss_locked", 32'(locked), 32'h0);
    check("loss_S", 32'(S), 32'h0);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0);
    check("loss_S_hold", 32'(S), 32'h0);
    check("loss_O_hold", 32'(O), 32'hA);

    // Asynchronous reset mid-frame
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    check("pre_rst_S", 32'(S), 32'h2);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_O", 32'(O), 32'h0);
    check("arst_S", 32'(S), 32'h0);
    check("arst_locked", 32'(locked), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(4'b0110);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    check("post_rst_O", 32'(O), 32'h6);
    check("post_rst_locked", 32'(locked), 32'h1);

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receive end of the 4:1 slot-select mux link. It takes the single serial lane the mux drives plus a frame-sync marker, tracks the slot sequence 0→1→2→3 itself, and reassembles the four channels into a parallel, double-buffered output word with a one-cycle frame-valid strobe. It sits directly downstream of the 4:1 mux and regenerates the select index that the transmitter stepped through.

## Interface
- WIDTH, 1, bits carried per slot (width of the mux data lane)
- MISS_MAX, 2, consecutive slot-0 beats without sync tolerated in LOCKED before dropping to HUNT; legal range 1–7

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- din  input  WIDTH  serial lane (mux output Y)
- en  input  1  slot strobe; din is valid and one slot is consumed when en=1
- sync  input  1  frame marker; qualified only with en=1; marks slot 0
- O  output  4*WIDTH  reassembled frame; slot k at O[k*WIDTH +: WIDTH]
- S  output  2  slot index the next en beat will be written to
- frame_valid  output  1  one-cycle pulse when O is updated
- locked  output  1  high in LOCKED state
- sync_err  output  1  one-cycle pulse on sync seen at S≠0

## Operation
- Reset values: O=0, S=0, frame_valid=0, sync_err=0, locked=0, state=HUNT, miss counter=0, shadow buffer=0.
- States: HUNT, LOCKED.
- HUNT: en beats with sync=0 are ignored and S stays 0. On en=1 with sync=1: din→shadow slot 0, S→1, state→LOCKED.
- LOCKED, en=1, sync=0, S≠0: din→shadow slot S; S→S+1 (mod 4, 3 wraps to 0).
- LOCKED, en=1, S=0, sync=1: normal frame start; capture slot 0; S→1; miss counter cleared.
- LOCKED, en=1, S=0, sync=0: flywheel; capture slot 0 and S→1. Miss counter increments. When the incremented count reaches MISS_MAX: beat is discarded, state→HUNT, S→0, miss counter cleared.
- LOCKED, en=1, sync=1, S≠0: resync. Pulse sync_err, discard partial shadow contents (no frame_valid), treat the beat as slot 0: capture din, S→1. Miss counter cleared.
- Frame completion: an accepted beat at S=3 copies shadow slots 0–2 plus the current din into O and pulses frame_valid. O holds its value until the next completed frame.
- en=0: no state change; outputs hold; frame_valid and sync_err return to 0.
- S wraps 3→0 only via a completed frame. Partial frames never reach O.

## Timing
- All outputs are registered. Nothing on the output side is combinational from the inputs.
- The slot capture is visible in S one cycle after the en beat.
- O and frame_valid update on the clock edge that samples the slot-3 beat. They are observable in the following cycle, so latency is 1 clk from the last beat.
- Back-to-back en beats every cycle are supported. The sustained rate is one frame per 4 clk, and frame_valid may pulse every 4th cycle.
- sync_err is high for exactly the cycle after the offending beat.
- Asynchronous rst_n assertion mid-frame clears everything immediately, including the partial shadow. After deassertion the block restarts in HUNT.

## Test plan
- Reset then HUNT: rst_n low 3 clk, then en beats with sync=0 and din=1 → S=0, locked=0, O=0, frame_valid never pulses.
- Clean frames (WIDTH=1): drive en every cycle, sync on slot 0, din slots = 1,0,1,1 → 1 clk after the 4th beat, O=4'b1101 and frame_valid high exactly 1 clk. Repeat with 0,1,1,0 → O=4'b0110 on the next pulse.
- Gapped strobe: the same frame with en low 2 clk between beats → identical O. S holds during the gaps.
- Misaligned sync: while LOCKED at S=2, drive en+sync with din=1 → sync_err pulse, no frame_valid, S=1 next cycle. Three more beats 0,0,1 → O=4'b1001.
- Sync loss, MISS_MAX=2: one frame with sync missing at slot 0 → O still updates and locked stays 1. A second consecutive miss → locked=0 and S=0, with no frame_valid for that frame.
- Reset mid-frame: assert rst_n low asynchronously at S=2 → O=0, S=0, locked=0 with no clock edge. The next synced frame decodes correctly.
